// File: rtl/reg_scoreboard_pkg.sv
// Shared types and defaults for the register scoreboard.
package reg_scoreboard_pkg;

  localparam int DEFAULT_NUM_REGS = 16;
  localparam int DEFAULT_MAX_PEND = 3;
  localparam int REG_ID_W         = $clog2(DEFAULT_NUM_REGS);

  typedef logic [REG_ID_W-1:0] RegisterID;

  typedef enum logic [1:0] {
    INIT  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } sb_state_t;

endpackage

// File: rtl/reg_scoreboard_pend_counter.sv
// Per-register in-flight write counter; a same-cycle inc and dec cancel out.
module reg_pend_counter #(
  parameter int MAX_PEND = 3,
  localparam int CW = $clog2(MAX_PEND + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          inc,
  input  logic          dec,
  input  logic          clr,
  output logic [CW-1:0] count,
  output logic          underflow
);

  assign underflow = dec && !clr && (count == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && !dec && (count != CW'(MAX_PEND))) begin
      count <= count + 1'b1;
    end else if (dec && !inc && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

endmodule

// File: rtl/reg_scoreboard.sv
// Register scoreboard: tracks in-flight writes per register and gates issue on RAW / saturation hazards.
// Optional stall statistics counter enabled by defining REG_SCOREBOARD_STATS_EN.
module reg_scoreboard
  import reg_scoreboard_pkg::*;
#(
  parameter int NUM_REGS = DEFAULT_NUM_REGS,
  parameter int MAX_PEND = DEFAULT_MAX_PEND,
  localparam int RW = $clog2(NUM_REGS),
  localparam int CW = $clog2(MAX_PEND + 1)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                issue_valid,
  output logic                issue_ready,
  input  logic                src0_en,
  input  logic [RW-1:0]       src0,
  input  logic                src1_en,
  input  logic [RW-1:0]       src1,
  input  logic                dst_en,
  input  logic [RW-1:0]       dst,
  input  logic                wb_valid,
  input  logic [RW-1:0]       wb_reg,
  input  logic                flush,
  output logic [NUM_REGS-1:0] busy_mask,
  output logic                err_underflow
`ifdef REG_SCOREBOARD_STATS_EN
  ,
  output logic [31:0]         stall_cycles
`endif
);

  sb_state_t state;
  sb_state_t state_next;

  logic [CW-1:0]       counts [NUM_REGS];
  logic [NUM_REGS-1:0] underflow_vec;
  logic                src0_hit;
  logic                src1_hit;
  logic                dst_full;
  logic                fire;
  logic                wb_live;
  logic                clr_all;

  function automatic logic in_range(input logic [RW-1:0] idx);
    return {1'b0, idx} < (RW + 1)'(NUM_REGS);
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= INIT;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      INIT:    state_next = RUN;
      RUN:     if (flush) state_next = FLUSH;
      FLUSH:   if (!flush) state_next = RUN;
      default: state_next = INIT;
    endcase
  end

  // Hazards look only at registered counters; a writeback frees a register one cycle later.
  always_comb begin
    src0_hit    = src0_en && in_range(src0) && (counts[src0] != '0);
    src1_hit    = src1_en && in_range(src1) && (counts[src1] != '0);
    dst_full    = dst_en && in_range(dst) && (counts[dst] == CW'(MAX_PEND));
    issue_ready = (state == RUN) && !(src0_hit || src1_hit || dst_full);
  end

  assign fire    = issue_valid && issue_ready;
  assign clr_all = (state == RUN) && flush;
  assign wb_live = wb_valid && (state == RUN) && !flush;

  genvar i;
  generate
    for (i = 0; i < NUM_REGS; i++) begin : g_reg
      logic inc;
      logic dec;

      assign inc = fire && dst_en && (dst == RW'(i));
      assign dec = wb_live && (wb_reg == RW'(i));

      reg_pend_counter #(
        .MAX_PEND (MAX_PEND)
      ) u_cnt (
        .clk       (clk),
        .rst_n     (rst_n),
        .inc       (inc),
        .dec       (dec),
        .clr       (clr_all),
        .count     (counts[i]),
        .underflow (underflow_vec[i])
      );

      assign busy_mask[i] = (counts[i] != '0);
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_underflow <= 1'b0;
    end else if (|underflow_vec) begin
      err_underflow <= 1'b1;
    end
  end

`ifdef REG_SCOREBOARD_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cycles <= '0;
    end else if ((state == RUN) && issue_valid && !issue_ready && (stall_cycles != '1)) begin
      stall_cycles <= stall_cycles + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_reg_scoreboard.sv
// Self-checking bench for reg_scoreboard: a reference model pushes expectations, DUT outputs pop and compare.
module tb_reg_scoreboard;
  import reg_scoreboard_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        issue_valid;
  logic        issue_ready;
  logic        src0_en;
  RegisterID   src0;
  logic        src1_en;
  RegisterID   src1;
  logic        dst_en;
  RegisterID   dst;
  logic        wb_valid;
  RegisterID   wb_reg;
  logic        flush;
  logic [15:0] busy_mask;
  logic        err_underflow;
`ifdef REG_SCOREBOARD_STATS_EN
  logic [31:0] stall_cycles;
`endif

  reg_scoreboard dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .issue_valid   (issue_valid),
    .issue_ready   (issue_ready),
    .src0_en       (src0_en),
    .src0          (src0),
    .src1_en       (src1_en),
    .src1          (src1),
    .dst_en        (dst_en),
    .dst           (dst),
    .wb_valid      (wb_valid),
    .wb_reg        (wb_reg),
    .flush         (flush),
    .busy_mask     (busy_mask),
    .err_underflow (err_underflow)
`ifdef REG_SCOREBOARD_STATS_EN
    ,
    .stall_cycles  (stall_cycles)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  exp_t      expq[$];
  int        vectors = 0;
  int        miscompares = 0;

  sb_state_t   mstate;
  int          mcnt [16];
  logic        merr;
  logic [31:0] mstall;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic popCheck(input logic [31:0] got);
    exp_t e;
    if (expq.size() == 0) begin
      checkOutput("queue_empty", 32'd1, 32'd0);
    end else begin
      e = expq.pop_front();
      checkOutput(e.tag, got, e.val);
    end
  endtask

  task automatic modelReset();
    mstate = INIT;
    for (int k = 0; k < 16; k++) mcnt[k] = 0;
    merr   = 1'b0;
    mstall = '0;
  endtask

  function automatic logic modelReady(input logic s0e, input RegisterID s0, input logic s1e,
                                      input RegisterID s1, input logic de, input RegisterID d);
    if (mstate != RUN) return 1'b0;
    if (s0e && mcnt[s0] != 0) return 1'b0;
    if (s1e && mcnt[s1] != 0) return 1'b0;
    if (de && mcnt[d] == DEFAULT_MAX_PEND) return 1'b0;
    return 1'b1;
  endfunction

  function automatic logic [15:0] modelBusy();
    logic [15:0] b;
    for (int k = 0; k < 16; k++) b[k] = (mcnt[k] != 0);
    return b;
  endfunction

  task automatic modelStep(input logic v, input logic de, input RegisterID d, input logic wv,
                           input RegisterID wr, input logic fl, input logic rdy);
    logic fire;
    fire = v && rdy;
    if (mstate == RUN && v && !rdy && mstall != 32'hFFFF_FFFF) mstall = mstall + 1;
    if (mstate == RUN && fl) begin
      for (int k = 0; k < 16; k++) mcnt[k] = 0;
    end else if (mstate == RUN) begin
      if (wv && fire && de && d == wr) begin
        if (mcnt[wr] == 0) merr = 1'b1;
      end else begin
        if (fire && de && mcnt[d] < DEFAULT_MAX_PEND) mcnt[d]++;
        if (wv) begin
          if (mcnt[wr] != 0) mcnt[wr]--;
          else merr = 1'b1;
        end
      end
    end
    case (mstate)
      INIT:    mstate = RUN;
      RUN:     mstate = fl ? FLUSH : RUN;
      default: mstate = fl ? FLUSH : RUN;
    endcase
  endtask

  // Drives one cycle of inputs, checks ready before the edge and state outputs just after it.
  task automatic applyStimulus(input logic v, input logic s0e, input RegisterID s0,
                               input logic s1e, input RegisterID s1, input logic de,
                               input RegisterID d, input logic wv, input RegisterID wr,
                               input logic fl);
    logic rdy;
    issue_valid = v;  src0_en = s0e; src0 = s0; src1_en = s1e; src1 = s1;
    dst_en = de; dst = d; wb_valid = wv; wb_reg = wr; flush = fl;
    rdy = modelReady(s0e, s0, s1e, s1, de, d);
    expq.push_back('{"issue_ready", {31'd0, rdy}});
    #2;
    popCheck({31'd0, issue_ready});
    @(posedge clk);
    modelStep(v, de, d, wv, wr, fl, rdy);
    expq.push_back('{"busy_mask", {16'd0, modelBusy()}});
    expq.push_back('{"err_underflow", {31'd0, merr}});
`ifdef REG_SCOREBOARD_STATS_EN
    expq.push_back('{"stall_cycles", mstall});
`endif
    #1;
    popCheck({16'd0, busy_mask});
    popCheck({31'd0, err_underflow});
`ifdef REG_SCOREBOARD_STATS_EN
    popCheck(stall_cycles);
`endif
  endtask

  task automatic idleCycle();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic issueDst(input RegisterID d);
    applyStimulus(1, 0, 0, 0, 0, 1, d, 0, 0, 0);
  endtask

  task automatic writeBack(input RegisterID r);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, r, 0);
  endtask

  initial begin
    rst_n = 1'b0;
    issue_valid = 0; src0_en = 0; src0 = 0; src1_en = 0; src1 = 0;
    dst_en = 0; dst = 0; wb_valid = 0; wb_reg = 0; flush = 0;
    modelReset();
    #12;
    checkOutput("reset_ready", {31'd0, issue_ready}, 32'd0);
    checkOutput("reset_busy", {16'd0, busy_mask}, 32'd0);
    checkOutput("reset_err", {31'd0, err_underflow}, 32'd0);
    rst_n = 1'b1;

    // Reset release: INIT cycle holds ready low, then dst=3 fires.
    issueDst(3);
    issueDst(3);
    writeBack(3);

    // RAW hazard on r5, released the cycle after the writeback edge.
    issueDst(5);
    applyStimulus(1, 1, 5, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(1, 1, 5, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(1, 1, 5, 0, 0, 0, 0, 1, 5, 0);
    applyStimulus(1, 1, 5, 0, 0, 0, 0, 0, 0, 0);

    // Saturation of r2, ten stalled cycles, unrelated r7 still accepted.
    issueDst(2);
    issueDst(2);
    issueDst(2);
    for (int k = 0; k < 10; k++) issueDst(2);
    applyStimulus(1, 1, 7, 0, 0, 1, 7, 0, 0, 0);
    writeBack(7);
    for (int k = 0; k < 3; k++) writeBack(2);

    // Simultaneous fire/writeback: same register cancels, different registers both apply.
    issueDst(4);
    applyStimulus(1, 0, 0, 0, 0, 1, 4, 1, 4, 0);
    applyStimulus(1, 0, 0, 0, 0, 1, 10, 1, 4, 0);
    writeBack(10);

    // Flush clears counters; writebacks during the flush are ignored without error.
    issueDst(1);
    issueDst(1);
    issueDst(6);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 1, 1);
    applyStimulus(1, 0, 0, 0, 0, 1, 0, 1, 1, 1);
    applyStimulus(1, 0, 0, 0, 0, 1, 0, 1, 1, 0);
    issueDst(0);
    writeBack(0);

    // Underflow is sticky.
    writeBack(9);
    idleCycle();
    issueDst(9);
    writeBack(9);

    for (int k = 0; k < 300; k++) begin
      applyStimulus(($urandom_range(0, 9) < 7), $urandom_range(0, 1), RegisterID'($urandom_range(0, 7)),
                    $urandom_range(0, 1), RegisterID'($urandom_range(0, 7)), $urandom_range(0, 1),
                    RegisterID'($urandom_range(0, 7)), ($urandom_range(0, 9) < 4),
                    RegisterID'($urandom_range(0, 7)), ($urandom_range(0, 19) == 0));
    end
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    // Mid-operation reset drops all pending state.
    issueDst(5);
    issueDst(6);
    rst_n = 1'b0;
    #2;
    checkOutput("midreset_busy", {16'd0, busy_mask}, 32'd0);
    checkOutput("midreset_ready", {31'd0, issue_ready}, 32'd0);
    checkOutput("midreset_err", {31'd0, err_underflow}, 32'd0);
    modelReset();
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(1, 1, 5, 0, 0, 1, 6, 0, 0, 0);
    applyStimulus(1, 1, 5, 0, 0, 1, 6, 0, 0, 0);
    writeBack(6);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
